// File: rtl/icache_pkg.sv
// Shared types and geometry constants for the L1 instruction-cache refill path.
package icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FILL,
    DRAIN,
    DONE
  } refill_state_t;

  localparam int ICACHE_B   = 4;
  localparam int WORD_OFF_W = 2;                          // byte offset within a word
  localparam int LINE_OFF_W = $clog2(ICACHE_B) + WORD_OFF_W;

endpackage

// File: rtl/refill_beat_ctr.sv
// Beat counter for one line refill: counts received beats and produces the
// wrapped word index within the line plus a last-beat flag.
module refill_beat_ctr #(
  parameter  int B  = 4,
  localparam int IW = $clog2(B),
  localparam int CW = IW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  input  logic [IW-1:0] start_word,
  output logic [IW-1:0] idx,
  output logic          last
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Truncation to IW bits gives the modulo-B wrap for critical-word-first order.
  assign idx  = start_word + cnt[IW-1:0];
  assign last = (cnt == CW'(B - 1));

endmodule

// File: rtl/instr_cache_refill.sv
// L1 I-cache line-refill engine: fetches one B-word line on a permitted miss and
// streams it into the cache. Optional ICACHE_CRIT_WORD_FIRST_EN fetches critical word first.
module instr_cache_refill
  import icache_pkg::*;
#(
  parameter int B      = ICACHE_B,
  parameter int WORD_W = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 instr_hit_f_i,
  input  logic                 ic_repl_permit_i,
  input  logic                 flush_i,
  input  logic [WORD_W-1:0]    pc_f_i,
  output logic                 mem_req_o,
  output logic [WORD_W-1:0]    mem_addr_o,
  input  logic                 mem_ack_i,
  input  logic                 mem_rvalid_i,
  input  logic [WORD_W-1:0]    mem_rdata_i,
  output logic                 line_we_o,
  output logic [$clog2(B)-1:0] line_word_o,
  output logic [WORD_W-1:0]    line_wdata_o,
  output logic                 fill_done_o,
  output logic                 refill_busy_o
);

  localparam int IW  = $clog2(B);
  localparam int LOW = IW + WORD_OFF_W;

  refill_state_t state;
  logic          abort;
  logic [IW-1:0] start_word;
  logic [IW-1:0] sw_next;
  logic [WORD_W-1:0] addr_next;
  logic          start;
  logic          cnt_clear;
  logic          cnt_inc;
  logic          last;
  logic          unused_pc;

`ifdef ICACHE_CRIT_WORD_FIRST_EN
  assign addr_next = {pc_f_i[WORD_W-1:WORD_OFF_W], {WORD_OFF_W{1'b0}}};
  assign sw_next   = pc_f_i[LOW-1:WORD_OFF_W];
  assign unused_pc = ^pc_f_i[WORD_OFF_W-1:0];
`else
  assign addr_next = {pc_f_i[WORD_W-1:LOW], {LOW{1'b0}}};
  assign sw_next   = '0;
  assign unused_pc = ^pc_f_i[LOW-1:0];
`endif

  assign start     = (state == IDLE) & ~instr_hit_f_i & ic_repl_permit_i & ~flush_i;
  assign cnt_clear = start | ((state == REQ) & mem_ack_i);
  assign cnt_inc   = mem_rvalid_i & ((state == FILL) | (state == DRAIN));

  // A beat arriving together with a flush is counted but never written.
  assign line_we_o    = (state == FILL) & mem_rvalid_i & ~flush_i;
  assign line_wdata_o = mem_rdata_i;

  refill_beat_ctr #(.B(B)) u_beat_ctr (
    .clk        (clk_i),
    .rst        (reset_i),
    .clear      (cnt_clear),
    .inc        (cnt_inc),
    .start_word (start_word),
    .idx        (line_word_o),
    .last       (last)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= IDLE;
      abort         <= 1'b0;
      start_word    <= '0;
      mem_addr_o    <= '0;
      mem_req_o     <= 1'b0;
      fill_done_o   <= 1'b0;
      refill_busy_o <= 1'b0;
    end else begin
      fill_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= REQ;
            mem_addr_o    <= addr_next;
            start_word    <= sw_next;
            abort         <= 1'b0;
            mem_req_o     <= 1'b1;
            refill_busy_o <= 1'b1;
          end
        end
        REQ: begin
          // The request stays up until accepted; a flush only marks the beats for discard.
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            abort     <= 1'b0;
            state     <= (abort | flush_i) ? DRAIN : FILL;
          end else if (flush_i) begin
            abort <= 1'b1;
          end
        end
        FILL: begin
          if (mem_rvalid_i && last) begin
            state         <= flush_i ? IDLE : DONE;
            fill_done_o   <= ~flush_i;
            refill_busy_o <= ~flush_i;
          end else if (flush_i) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_rvalid_i && last) begin
            state         <= IDLE;
            refill_busy_o <= 1'b0;
          end
        end
        DONE: begin
          state         <= IDLE;
          refill_busy_o <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          mem_req_o     <= 1'b0;
          refill_busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_cache_refill.sv
// Self-checking bench for instr_cache_refill: directed scenarios plus randomized
// refills checked against an arithmetic model of address, write order and completion.
module tb_instr_cache_refill;

  localparam int B      = 4;
  localparam int WORD_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              hit, permit, flush;
  logic [WORD_W-1:0] pc;
  logic              mem_req;
  logic [WORD_W-1:0] mem_addr;
  logic              ack, rvalid;
  logic [WORD_W-1:0] rdata;
  logic              line_we;
  logic [1:0]        line_word;
  logic [WORD_W-1:0] line_wdata;
  logic              fill_done, busy;

  int n_tests = 0;
  int n_fail  = 0;

  int                wr_idx[$];
  logic [WORD_W-1:0] wr_dat[$];
  int                done_cnt;
  logic [WORD_W-1:0] beat_data[B];

  instr_cache_refill #(.B(B), .WORD_W(WORD_W)) dut (
    .clk_i            (clk),
    .reset_i          (rst),
    .instr_hit_f_i    (hit),
    .ic_repl_permit_i (permit),
    .flush_i          (flush),
    .pc_f_i           (pc),
    .mem_req_o        (mem_req),
    .mem_addr_o       (mem_addr),
    .mem_ack_i        (ack),
    .mem_rvalid_i     (rvalid),
    .mem_rdata_i      (rdata),
    .line_we_o        (line_we),
    .line_word_o      (line_word),
    .line_wdata_o     (line_wdata),
    .fill_done_o      (fill_done),
    .refill_busy_o    (busy)
  );

  always #5 clk = ~clk;

  // Observe cache-side writes and completion pulses mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (line_we) begin
        wr_idx.push_back(int'(line_word));
        wr_dat.push_back(line_wdata);
      end
      if (fill_done) done_cnt++;
    end
  end

  // Reference model: where the line is requested and which slot beat k lands in.
  function automatic logic [WORD_W-1:0] exp_addr(input logic [WORD_W-1:0] p);
`ifdef ICACHE_CRIT_WORD_FIRST_EN
    return p & ~32'h3;
`else
    return p & ~32'(B * 4 - 1);
`endif
  endfunction

  function automatic int exp_idx(input logic [WORD_W-1:0] p, input int k);
    int sw;
`ifdef ICACHE_CRIT_WORD_FIRST_EN
    sw = int'((p / 4) % B);
`else
    sw = 0;
`endif
    return (sw + k) % B;
  endfunction

  task automatic clear_obs();
    wr_idx.delete();
    wr_dat.delete();
    done_cnt = 0;
  endtask

  // Drives one complete miss/refill transaction as the memory side would.
  // flush_fill = k (0..B-1) flushes in an idle cycle just before beat k; -1 = none.
  task automatic do_refill(input logic [WORD_W-1:0] p, input int ack_dly,
                           input bit flush_req, input int flush_fill,
                           output int req_bad, output int req_after_ack,
                           output logic done_next, output logic busy_next,
                           output logic busy_next2);
    int gap;
    clear_obs();
    req_bad = 0;
    req_after_ack = 0;
    @(posedge clk); #1;
    hit = 1'b0; permit = 1'b1; pc = p;
    @(posedge clk); #1;
    hit = 1'b1; permit = 1'b0;
    if (flush_req) flush = 1'b1;
    for (int d = 0; d <= ack_dly; d++) begin
      ack = (d == ack_dly);
      @(negedge clk);
      if (mem_req !== 1'b1 || mem_addr !== exp_addr(p)) req_bad++;
      @(posedge clk); #1;
      flush = 1'b0; ack = 1'b0;
    end
    for (int k = 0; k < B; k++) begin
      gap = $urandom_range(0, 2);
      if (flush_fill == k && gap == 0) gap = 1;
      for (int g = 0; g < gap; g++) begin
        rvalid = 1'b0;
        if (flush_fill == k && g == gap - 1) flush = 1'b1;
        @(negedge clk);
        if (mem_req !== 1'b0) req_after_ack++;
        @(posedge clk); #1;
        flush = 1'b0;
      end
      rvalid = 1'b1;
      rdata = $urandom;
      beat_data[k] = rdata;
      @(negedge clk);
      if (mem_req !== 1'b0) req_after_ack++;
      @(posedge clk); #1;
      rvalid = 1'b0;
    end
    @(negedge clk);
    done_next = fill_done;
    busy_next = busy;
    @(negedge clk);
    busy_next2 = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({mem_req, line_we, fill_done, busy} !== 4'b0 || mem_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req/we/done/busy=%b addr=%h, want 0000 addr=0",
               {mem_req, line_we, fill_done, busy}, mem_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic_fill();
    int rb, ra; logic dn, b1, b2;
    logic [WORD_W-1:0] p = 32'h0000_1044;
    do_refill(p, 2, 1'b0, -1, rb, ra, dn, b1, b2);
    n_tests++;
    if (rb != 0 || ra != 0) begin
      n_fail++;
      $display("FAIL basic_req: bad req cycles=%0d req after ack=%0d, want 0 0 (addr want %h)",
               rb, ra, exp_addr(p));
    end
    n_tests++;
    if (wr_idx.size() != B) begin
      n_fail++;
      $display("FAIL basic_wr_count: got %0d writes, want %0d", wr_idx.size(), B);
    end
    for (int k = 0; k < B && k < wr_idx.size(); k++) begin
      n_tests++;
      if (wr_idx[k] != exp_idx(p, k) || wr_dat[k] !== beat_data[k]) begin
        n_fail++;
        $display("FAIL basic_wr%0d: idx=%0d data=%h, want idx=%0d data=%h",
                 k, wr_idx[k], wr_dat[k], exp_idx(p, k), beat_data[k]);
      end
    end
    n_tests++;
    if (dn !== 1'b1 || done_cnt != 1 || b1 !== 1'b1 || b2 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: next=%b count=%0d busy=%b,%b, want 1 1 busy=1,0",
               dn, done_cnt, b1, b2);
    end
  endtask

  task automatic test_flush_fill();
    int rb, ra; logic dn, b1, b2;
    logic [WORD_W-1:0] p = 32'h0000_2238;
    do_refill(p, 1, 1'b0, 1, rb, ra, dn, b1, b2);
    n_tests++;
    if (wr_idx.size() != 1) begin
      n_fail++;
      $display("FAIL flushfill_count: got %0d writes, want 1", wr_idx.size());
    end else begin
      n_tests++;
      if (wr_idx[0] != exp_idx(p, 0) || wr_dat[0] !== beat_data[0]) begin
        n_fail++;
        $display("FAIL flushfill_wr0: idx=%0d data=%h, want idx=%0d data=%h",
                 wr_idx[0], wr_dat[0], exp_idx(p, 0), beat_data[0]);
      end
    end
    n_tests++;
    if (done_cnt != 0 || b1 !== 1'b0) begin
      n_fail++;
      $display("FAIL flushfill_end: done=%0d busy=%b, want 0 0", done_cnt, b1);
    end
  endtask

  task automatic test_flush_req();
    int rb, ra; logic dn, b1, b2;
    logic [WORD_W-1:0] p = 32'h0001_0010;
    do_refill(p, 3, 1'b1, -1, rb, ra, dn, b1, b2);
    n_tests++;
    if (rb != 0) begin
      n_fail++;
      $display("FAIL flushreq_hold: bad req cycles=%0d, want 0", rb);
    end
    n_tests++;
    if (wr_idx.size() != 0 || done_cnt != 0 || b1 !== 1'b0) begin
      n_fail++;
      $display("FAIL flushreq_drain: writes=%0d done=%0d busy=%b, want 0 0 0",
               wr_idx.size(), done_cnt, b1);
    end
  endtask

  task automatic test_permit();
    int rb, ra; int bad = 0; logic dn, b1, b2;
    logic [WORD_W-1:0] p = 32'h0000_30A4;
    @(posedge clk); #1;
    hit = 1'b0; permit = 1'b0; pc = p;
    repeat (3) begin
      @(negedge clk);
      if (mem_req !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL permit_blocked: %0d cycles busy/req, want 0", bad);
    end
    do_refill(p, 0, 1'b0, -1, rb, ra, dn, b1, b2);
    n_tests++;
    if (rb != 0 || wr_idx.size() != B || done_cnt != 1) begin
      n_fail++;
      $display("FAIL permit_start: badreq=%0d writes=%0d done=%0d, want 0 %0d 1",
               rb, wr_idx.size(), done_cnt, B);
    end
  endtask

  task automatic test_async_reset();
    int rb, ra; logic dn, b1, b2;
    logic [WORD_W-1:0] p = 32'h0000_4400;
    @(posedge clk); #1;
    hit = 1'b0; permit = 1'b1; pc = p;
    @(posedge clk); #1;
    hit = 1'b1; permit = 1'b0; ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0; rvalid = 1'b1; rdata = 32'hA5A5_0000;
    @(posedge clk); #1;
    rdata = 32'hA5A5_0001;
    n_tests++;
    if (line_we !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_midfill: we=%b busy=%b, want 1 1", line_we, busy);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({mem_req, line_we, fill_done, busy} !== 4'b0 || mem_addr !== '0) begin
      n_fail++;
      $display("FAIL areset_immediate: req/we/done/busy=%b addr=%h, want 0000 0",
               {mem_req, line_we, fill_done, busy}, mem_addr);
    end
    @(posedge clk); #1;
    rvalid = 1'b0;
    rst = 1'b0;
    do_refill(32'h0000_5508, 1, 1'b0, -1, rb, ra, dn, b1, b2);
    n_tests++;
    if (wr_idx.size() != B || done_cnt != 1) begin
      n_fail++;
      $display("FAIL areset_refill: writes=%0d done=%0d, want %0d 1", wr_idx.size(), done_cnt, B);
    end
    for (int k = 0; k < B && k < wr_idx.size(); k++) begin
      n_tests++;
      if (wr_idx[k] != exp_idx(32'h0000_5508, k) || wr_dat[k] !== beat_data[k]) begin
        n_fail++;
        $display("FAIL areset_wr%0d: idx=%0d data=%h, want idx=%0d data=%h",
                 k, wr_idx[k], wr_dat[k], exp_idx(32'h0000_5508, k), beat_data[k]);
      end
    end
  endtask

  task automatic test_random();
    int rb, ra, mode, f, n_exp; logic dn, b1, b2;
    logic [WORD_W-1:0] p;
    for (int it = 0; it < 10; it++) begin
      p = $urandom;
      mode = $urandom_range(0, 2);
      f = $urandom_range(0, B - 1);
      do_refill(p, $urandom_range(0, 3), mode == 1, (mode == 2) ? f : -1,
                rb, ra, dn, b1, b2);
      n_exp = (mode == 0) ? B : (mode == 1) ? 0 : f;
      n_tests++;
      if (rb != 0 || ra != 0 || wr_idx.size() != n_exp) begin
        n_fail++;
        $display("FAIL rand%0d_shape: badreq=%0d reqafter=%0d writes=%0d, want 0 0 %0d",
                 it, rb, ra, wr_idx.size(), n_exp);
      end
      for (int k = 0; k < n_exp && k < wr_idx.size(); k++) begin
        n_tests++;
        if (wr_idx[k] != exp_idx(p, k) || wr_dat[k] !== beat_data[k]) begin
          n_fail++;
          $display("FAIL rand%0d_wr%0d: idx=%0d data=%h, want idx=%0d data=%h",
                   it, k, wr_idx[k], wr_dat[k], exp_idx(p, k), beat_data[k]);
        end
      end
      n_tests++;
      if (done_cnt != ((mode == 0) ? 1 : 0) || b1 !== (mode == 0) || b2 !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d_end: done=%0d busy=%b,%b, want %0d busy=%b,0",
                 it, done_cnt, b1, b2, (mode == 0) ? 1 : 0, mode == 0);
      end
    end
  endtask

  initial begin
    hit = 1'b1; permit = 1'b0; flush = 1'b0; pc = '0;
    ack = 1'b0; rvalid = 1'b0; rdata = '0;
    done_cnt = 0;
    test_reset();
    test_basic_fill();
    test_flush_fill();
    test_flush_req();
    test_permit();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
